multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 154 +++++++++++++++
 tb/tb_multicycle_controller.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle RISC-V style control FSM with a memory-wait watchdog.
// Optional: define MULTICYCLE_LUI_EN to add the LUI execute state (code 11).
module multicycle_controller #(
   parameter int WAIT_W = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [6:0] i_opcode,
   input  logic       i_Zero,
   input  logic       i_MemReady,
   output logic       o_PCWrite,
   output logic       o_IRWrite,
   output logic       o_RegWrite,
   output logic       o_MemWrite,
   output logic       o_MemReq,
   output logic       o_AdrSrc,
   output logic [1:0] o_ResultSrc,
   output logic [1:0] o_ALUSrcA,
   output logic [1:0] o_ALUSrcB,
   output logic [1:0] o_ALUOp,
   output logic [3:0] o_State,
   output logic       o_Fault
);
   localparam logic [3:0] FETCH    = 4'd0;
   localparam logic [3:0] DECODE   = 4'd1;
   localparam logic [3:0] MEMADR   = 4'd2;
   localparam logic [3:0] MEMREAD  = 4'd3;
   localparam logic [3:0] MEMWB    = 4'd4;
   localparam logic [3:0] MEMWRITE = 4'd5;
   localparam logic [3:0] EXECR    = 4'd6;
   localparam logic [3:0] ALUWB    = 4'd7;
   localparam logic [3:0] EXECI    = 4'd8;
   localparam logic [3:0] JAL      = 4'd9;
   localparam logic [3:0] BEQ      = 4'd10;
   localparam logic [3:0] LUI      = 4'd11;
   localparam logic [3:0] FAULT    = 4'd15;

   logic [3:0]        state, nxt;
   logic [WAIT_W-1:0] cnt;
   logic              ready, wait_st, cnt_max;

   // Ready is masked during reset so no write strobe fires while held in FETCH.
   assign ready   = i_MemReady & i_rst_n;
   assign cnt_max = &cnt;
   assign wait_st = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
   assign o_State = state;
   assign o_Fault = (state == FAULT);

   always_comb begin
      nxt         = state;
      o_PCWrite   = 1'b0;
      o_IRWrite   = 1'b0;
      o_RegWrite  = 1'b0;
      o_MemWrite  = 1'b0;
      o_MemReq    = 1'b0;
      o_AdrSrc    = 1'b0;
      o_ResultSrc = 2'b00;
      o_ALUSrcA   = 2'b00;
      o_ALUSrcB   = 2'b00;
      o_ALUOp     = 2'b00;
      case (state)
         FETCH: begin
            o_MemReq    = 1'b1;
            o_ALUSrcB   = 2'b10;
            o_ResultSrc = 2'b10;
            o_IRWrite   = ready;
            o_PCWrite   = ready;
            nxt         = ready ? DECODE : (cnt_max ? FAULT : FETCH);
         end
         DECODE: begin
            o_ALUSrcA = 2'b01;
            o_ALUSrcB = 2'b01;
            case (i_opcode)
               7'b0000011, 7'b0100011: nxt = MEMADR;
               7'b0110011:             nxt = EXECR;
               7'b0010011:             nxt = EXECI;
               7'b1101111:             nxt = JAL;
               7'b1100011:             nxt = BEQ;
`ifdef MULTICYCLE_LUI_EN
               7'b0110111:             nxt = LUI;
`endif
               default:                nxt = FAULT;
            endcase
         end
         MEMADR: begin
            o_ALUSrcA = 2'b10;
            o_ALUSrcB = 2'b01;
            nxt       = (i_opcode == 7'b0000011) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            o_MemReq = 1'b1;
            o_AdrSrc = 1'b1;
            nxt      = ready ? MEMWB : (cnt_max ? FAULT : MEMREAD);
         end
         MEMWB: begin
            o_ResultSrc = 2'b01;
            o_RegWrite  = 1'b1;
            nxt         = FETCH;
         end
         MEMWRITE: begin
            o_MemReq   = 1'b1;
            o_MemWrite = 1'b1;
            o_AdrSrc   = 1'b1;
            nxt        = ready ? FETCH : (cnt_max ? FAULT : MEMWRITE);
         end
         EXECR: begin
            o_ALUSrcA = 2'b10;
            o_ALUOp   = 2'b10;
            nxt       = ALUWB;
         end
         EXECI: begin
            o_ALUSrcA = 2'b10;
            o_ALUSrcB = 2'b01;
            o_ALUOp   = 2'b10;
            nxt       = ALUWB;
         end
         ALUWB: begin
            o_RegWrite = 1'b1;
            nxt        = FETCH;
         end
         JAL: begin
            o_ALUSrcA = 2'b01;
            o_ALUSrcB = 2'b10;
            o_PCWrite = 1'b1;
            nxt       = ALUWB;
         end
         BEQ: begin
            o_ALUSrcA = 2'b10;
            o_ALUOp   = 2'b01;
            o_PCWrite = i_Zero;
            nxt       = FETCH;
         end
`ifdef MULTICYCLE_LUI_EN
         LUI: begin
            o_ALUSrcA = 2'b11;
            o_ALUSrcB = 2'b01;
            nxt       = ALUWB;
         end
`endif
         default: nxt = FAULT;
      endcase
   end

   // The watchdog restarts from zero whenever the state changes, so each wait state gets a full budget.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= FETCH;
         cnt   <= '0;
      end else begin
         state <= nxt;
         cnt   <= (nxt != state) ? '0 : ((wait_st && !ready) ? cnt + 1'b1 : cnt);
      end
   end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed vector table plus hand sequences for waits, watchdog and async reset.
module tb_multicycle_controller;
   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic [6:0] i_opcode = 7'd0;
   logic       i_Zero = 1'b0;
   logic       i_MemReady = 1'b0;
   logic       o_PCWrite, o_IRWrite, o_RegWrite, o_MemWrite, o_MemReq, o_AdrSrc;
   logic [1:0] o_ResultSrc, o_ALUSrcA, o_ALUSrcB, o_ALUOp;
   logic [3:0] o_State;
   logic       o_Fault;

   multicycle_controller #(.WAIT_W(4)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_opcode(i_opcode), .i_Zero(i_Zero),
      .i_MemReady(i_MemReady), .o_PCWrite(o_PCWrite), .o_IRWrite(o_IRWrite),
      .o_RegWrite(o_RegWrite), .o_MemWrite(o_MemWrite), .o_MemReq(o_MemReq),
      .o_AdrSrc(o_AdrSrc), .o_ResultSrc(o_ResultSrc), .o_ALUSrcA(o_ALUSrcA),
      .o_ALUSrcB(o_ALUSrcB), .o_ALUOp(o_ALUOp), .o_State(o_State), .o_Fault(o_Fault)
   );

   always #5 i_clk = ~i_clk;

   localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                          OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_BEQ = 7'b1100011,
                          OP_LUI = 7'b0110111, OP_BAD = 7'b0000000;
   // sel = {ResultSrc, ALUSrcA, ALUSrcB, ALUOp}; stb = {PCWrite, IRWrite, RegWrite, MemWrite, MemReq, AdrSrc}
   localparam logic [7:0] SEL_F = 8'b10_00_10_00, SEL_D = 8'b00_01_01_00, SEL_MA = 8'b00_10_01_00,
                          SEL_WB = 8'b01_00_00_00, SEL_XR = 8'b00_10_00_10, SEL_XI = 8'b00_10_01_10,
                          SEL_J = 8'b00_01_10_00, SEL_B = 8'b00_10_00_01, SEL_L = 8'b00_11_01_00,
                          SEL_0 = 8'b0;

   typedef struct {
      logic       rst_n;
      logic [6:0] op;
      logic       zero;
      logic       rdy;
      logic [3:0] st;
      logic [5:0] stb;
      logic [7:0] sel;
      logic       flt;
   } vec_t;

   vec_t v[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic add(input logic r, input logic [6:0] op, input logic z, input logic rdy,
                      input logic [3:0] st, input logic [5:0] stb, input logic [7:0] sel, input logic flt);
      vec_t t;
      t.rst_n = r; t.op = op; t.zero = z; t.rdy = rdy;
      t.st = st; t.stb = stb; t.sel = sel; t.flt = flt;
      v.push_back(t);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0;
      @(negedge i_clk);
      i_rst_n = 1'b1;
   endtask

   initial begin
      // reset, then R-type with zero wait
      add(0, OP_R,   0, 1, 4'd0,  6'b000010, SEL_F,  0);
      add(1, OP_R,   0, 1, 4'd0,  6'b110010, SEL_F,  0);
      add(1, OP_R,   0, 1, 4'd1,  6'b000000, SEL_D,  0);
      add(1, OP_R,   0, 1, 4'd6,  6'b000000, SEL_XR, 0);
      add(1, OP_R,   0, 1, 4'd7,  6'b001000, SEL_0,  0);
      // I-type
      add(1, OP_I,   0, 1, 4'd0,  6'b110010, SEL_F,  0);
      add(1, OP_I,   0, 1, 4'd1,  6'b000000, SEL_D,  0);
      add(1, OP_I,   0, 1, 4'd8,  6'b000000, SEL_XI, 0);
      add(1, OP_I,   0, 1, 4'd7,  6'b001000, SEL_0,  0);
      // jal
      add(1, OP_JAL, 0, 1, 4'd0,  6'b110010, SEL_F,  0);
      add(1, OP_JAL, 0, 1, 4'd1,  6'b000000, SEL_D,  0);
      add(1, OP_JAL, 0, 1, 4'd9,  6'b100000, SEL_J,  0);
      add(1, OP_JAL, 0, 1, 4'd7,  6'b001000, SEL_0,  0);
      // beq taken then not taken
      add(1, OP_BEQ, 1, 1, 4'd0,  6'b110010, SEL_F,  0);
      add(1, OP_BEQ, 1, 1, 4'd1,  6'b000000, SEL_D,  0);
      add(1, OP_BEQ, 1, 1, 4'd10, 6'b100000, SEL_B,  0);
      add(1, OP_BEQ, 0, 1, 4'd0,  6'b110010, SEL_F,  0);
      add(1, OP_BEQ, 0, 1, 4'd1,  6'b000000, SEL_D,  0);
      add(1, OP_BEQ, 0, 1, 4'd10, 6'b000000, SEL_B,  0);
      // lw with three not-ready cycles in MEMREAD
      add(1, OP_LW,  0, 1, 4'd0,  6'b110010, SEL_F,  0);
      add(1, OP_LW,  0, 1, 4'd1,  6'b000000, SEL_D,  0);
      add(1, OP_LW,  0, 1, 4'd2,  6'b000000, SEL_MA, 0);
      add(1, OP_LW,  0, 0, 4'd3,  6'b000011, SEL_0,  0);
      add(1, OP_LW,  0, 0, 4'd3,  6'b000011, SEL_0,  0);
      add(1, OP_LW,  0, 0, 4'd3,  6'b000011, SEL_0,  0);
      add(1, OP_LW,  0, 1, 4'd3,  6'b000011, SEL_0,  0);
      add(1, OP_LW,  0, 1, 4'd4,  6'b001000, SEL_WB, 0);
      // sw with two not-ready fetch cycles
      add(1, OP_SW,  0, 0, 4'd0,  6'b000010, SEL_F,  0);
      add(1, OP_SW,  0, 0, 4'd0,  6'b000010, SEL_F,  0);
      add(1, OP_SW,  0, 1, 4'd0,  6'b110010, SEL_F,  0);
      add(1, OP_SW,  0, 1, 4'd1,  6'b000000, SEL_D,  0);
      add(1, OP_SW,  0, 1, 4'd2,  6'b000000, SEL_MA, 0);
      add(1, OP_SW,  0, 1, 4'd5,  6'b000111, SEL_0,  0);
      // unsupported opcode faults and sticks, reset recovers
      add(1, OP_BAD, 0, 1, 4'd0,  6'b110010, SEL_F,  0);
      add(1, OP_BAD, 0, 1, 4'd1,  6'b000000, SEL_D,  0);
      add(1, OP_BAD, 1, 1, 4'd15, 6'b000000, SEL_0,  1);
      add(1, OP_BAD, 1, 1, 4'd15, 6'b000000, SEL_0,  1);
      add(0, OP_BAD, 0, 1, 4'd0,  6'b000010, SEL_F,  0);
      // lui depends on build option
      add(1, OP_LUI, 0, 1, 4'd0,  6'b110010, SEL_F,  0);
      add(1, OP_LUI, 0, 1, 4'd1,  6'b000000, SEL_D,  0);
`ifdef MULTICYCLE_LUI_EN
      add(1, OP_LUI, 0, 1, 4'd11, 6'b000000, SEL_L,  0);
      add(1, OP_LUI, 0, 1, 4'd7,  6'b001000, SEL_0,  0);
      add(1, OP_LUI, 0, 1, 4'd0,  6'b110010, SEL_F,  0);
`else
      add(1, OP_LUI, 0, 1, 4'd15, 6'b000000, SEL_0,  1);
      add(1, OP_LUI, 0, 1, 4'd15, 6'b000000, SEL_0,  1);
`endif

      #2;
      foreach (v[i]) begin
         i_rst_n = v[i].rst_n; i_opcode = v[i].op; i_Zero = v[i].zero; i_MemReady = v[i].rdy;
         #1;
         chk($sformatf("vec%0d", i),
             {13'd0, o_State, o_PCWrite, o_IRWrite, o_RegWrite, o_MemWrite, o_MemReq, o_AdrSrc,
              o_ResultSrc, o_ALUSrcA, o_ALUSrcB, o_ALUOp, o_Fault},
             {13'd0, v[i].st, v[i].stb, v[i].sel, v[i].flt});
         @(negedge i_clk);
      end

      // watchdog: 15 waits stay in FETCH, the 16th not-ready cycle faults
      i_MemReady = 1'b1;
      do_reset();
      i_MemReady = 1'b0;
      for (int k = 0; k < 16; k++) begin
         #1 chk($sformatf("wd_wait%0d", k), o_State, 4'd0);
         @(negedge i_clk);
      end
      chk("wd_fault_state", o_State, 4'd15);
      chk("wd_fault_flag", o_Fault, 1'b1);
      i_MemReady = 1'b1;
      @(negedge i_clk);
      chk("wd_fault_sticky", {o_Fault, o_MemReq}, 2'b10);
      i_rst_n = 1'b0;
      #1 chk("wd_reset_clears", {o_State, o_Fault}, 5'b0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      // same, but ready on the 16th cycle wins over the timeout
      i_MemReady = 1'b0;
      i_opcode = OP_R;
      repeat (15) @(negedge i_clk);
      chk("wd_edge_state", o_State, 4'd0);
      i_MemReady = 1'b1;
      #1 chk("wd_edge_irwrite", o_IRWrite, 1'b1);
      @(negedge i_clk);
      chk("wd_edge_decode", o_State, 4'd1);

      // the counter restarts per state: 10 fetch waits then 15 read waits do not fault
      i_opcode = OP_LW;
      do_reset();
      i_MemReady = 1'b0;
      repeat (10) @(negedge i_clk);
      i_MemReady = 1'b1;
      @(negedge i_clk);
      @(negedge i_clk);
      chk("cnt_memadr", o_State, 4'd2);
      i_MemReady = 1'b0;
      repeat (16) @(negedge i_clk);
      chk("cnt_memread_hold", {o_State, o_MemReq}, {4'd3, 1'b1});
      i_MemReady = 1'b1;
      @(negedge i_clk);
      chk("cnt_memwb", o_State, 4'd4);

      // asynchronous reset in the middle of a MEMWRITE wait
      i_opcode = OP_SW;
      do_reset();
      repeat (3) @(negedge i_clk);
      i_MemReady = 1'b0;
      chk("ar_memwrite", o_State, 4'd5);
      @(posedge i_clk);
      #2 chk("ar_memwrite_before", o_MemWrite, 1'b1);
      i_rst_n = 1'b0;
      #1 chk("ar_memwrite_drop", {o_MemWrite, o_State, o_MemReq, o_PCWrite}, {1'b0, 4'd0, 1'b1, 1'b0});
      @(negedge i_clk);
      i_rst_n = 1'b1;
      i_MemReady = 1'b1;
      #1 chk("ar_refetch", {o_State, o_IRWrite}, {4'd0, 1'b1});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
